// File: rtl/piso_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : piso_frame_ctrl
// Description : Sequencer and N-bit load/shift register for a PISO link.
//               Words come in on a valid/ready handshake and go out MSB-first
//               on a bit-serial valid/ready handshake. An inter-frame gap and
//               abort are supported. Optional macro PISO_PARITY_EN appends
//               one even-parity bit to each frame.
// Revision    : 1.0 - initial release
// ============================================================================
module piso_frame_ctrl #(
    parameter int N   = 4,
    parameter int GAP = 1,
    parameter int CW  = 8
) (
    input  logic          clk,
    input  logic          clear_n,
    input  logic [N-1:0]  in_data,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          abort,
    output logic          shld,
    output logic          ser_out,
    output logic          ser_valid,
    input  logic          ser_ready,
    output logic          ser_first,
    output logic          ser_last,
    output logic          busy,
    output logic [CW-1:0] frame_cnt
);

    localparam int              c_CNTW    = $clog2(N);
    localparam logic [c_CNTW-1:0] c_CNT_TOP = c_CNTW'(N - 1);
    localparam int              c_GW      = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [c_GW-1:0] c_GAP_TOP = c_GW'((GAP > 0) ? (GAP - 1) : 0);
    localparam bit              c_B2B     = (GAP == 0);
`ifdef PISO_PARITY_EN
    localparam bit              c_PAR_EN  = 1'b1;
`else
    localparam bit              c_PAR_EN  = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_PAR   = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    state_t              r_state, w_state_nx;
    logic [N-1:0]        r_shreg, w_shreg_nx;
    logic [c_CNTW-1:0]   r_cnt,   w_cnt_nx;
    logic [c_GW-1:0]     r_gap,   w_gap_nx;
    logic [CW-1:0]       r_frame_cnt, w_frame_nx;
    logic                r_par;
    logic                w_rdy;
    logic                w_accept;

    // Ready is gated by clear_n so it reads 0 while reset is held.
    always_comb begin
        w_rdy = 1'b0;
        case (r_state)
            S_IDLE:  w_rdy = ~abort;
            S_SHIFT: w_rdy = c_B2B && !c_PAR_EN && (r_cnt == '0) && ser_ready && !abort;
            S_PAR:   w_rdy = c_B2B && ser_ready && !abort;
            default: w_rdy = 1'b0;
        endcase
    end

    assign in_ready  = w_rdy & clear_n;
    assign w_accept  = in_valid & in_ready;
    assign frame_cnt = r_frame_cnt;

`ifdef PISO_PARITY_EN
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            r_par <= 1'b0;
        end else if (w_accept) begin
            r_par <= ^in_data;
        end
    end
`else
    assign r_par = 1'b0;
`endif

    always_comb begin
        w_state_nx = r_state;
        w_shreg_nx = r_shreg;
        w_cnt_nx   = r_cnt;
        w_gap_nx   = r_gap;
        w_frame_nx = r_frame_cnt;
        shld       = (r_state != S_IDLE);
        busy       = (r_state != S_IDLE);
        ser_out    = 1'b0;
        ser_valid  = 1'b0;
        ser_first  = 1'b0;
        ser_last   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_shreg_nx = in_data;
                    w_cnt_nx   = c_CNT_TOP;
                    w_state_nx = S_SHIFT;
                end
            end

            S_SHIFT: begin
                ser_valid = 1'b1;
                ser_out   = r_shreg[N-1];
                ser_first = (r_cnt == c_CNT_TOP);
                ser_last  = (r_cnt == '0) && !c_PAR_EN;
                if (abort) begin
                    w_state_nx = S_IDLE;
                    w_shreg_nx = '0;
                end else if (ser_ready) begin
                    w_shreg_nx = {r_shreg[N-2:0], 1'b0};
                    w_cnt_nx   = r_cnt - c_CNTW'(1);
                    if (r_cnt == '0) begin
                        w_cnt_nx = '0;
                        if (c_PAR_EN) begin
                            w_state_nx = S_PAR;
                        end else begin
                            w_frame_nx = r_frame_cnt + CW'(1);
                            if (w_accept) begin
                                w_shreg_nx = in_data;
                                w_cnt_nx   = c_CNT_TOP;
                                w_state_nx = S_SHIFT;
                            end else if (c_B2B) begin
                                w_state_nx = S_IDLE;
                            end else begin
                                w_state_nx = S_GAP;
                                w_gap_nx   = c_GAP_TOP;
                            end
                        end
                    end
                end
            end

            S_PAR: begin
                ser_valid = 1'b1;
                ser_out   = r_par;
                ser_last  = 1'b1;
                if (abort) begin
                    w_state_nx = S_IDLE;
                    w_shreg_nx = '0;
                end else if (ser_ready) begin
                    w_frame_nx = r_frame_cnt + CW'(1);
                    if (w_accept) begin
                        w_shreg_nx = in_data;
                        w_cnt_nx   = c_CNT_TOP;
                        w_state_nx = S_SHIFT;
                    end else if (c_B2B) begin
                        w_state_nx = S_IDLE;
                    end else begin
                        w_state_nx = S_GAP;
                        w_gap_nx   = c_GAP_TOP;
                    end
                end
            end

            S_GAP: begin
                // Abort is deliberately ignored here; the gap always completes.
                if (r_gap == '0) begin
                    w_state_nx = S_IDLE;
                end else begin
                    w_gap_nx = r_gap - c_GW'(1);
                end
            end

            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            r_state     <= S_IDLE;
            r_shreg     <= '0;
            r_cnt       <= '0;
            r_gap       <= '0;
            r_frame_cnt <= '0;
        end else begin
            r_state     <= w_state_nx;
            r_shreg     <= w_shreg_nx;
            r_cnt       <= w_cnt_nx;
            r_gap       <= w_gap_nx;
            r_frame_cnt <= w_frame_nx;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_piso_frame_ctrl.sv
`default_nettype none
// Testbench for piso_frame_ctrl: one instance with GAP=1, one with GAP=0.
module tb_piso_frame_ctrl;

    localparam int N = 4;
`ifdef PISO_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FL = N + PAR;

    typedef struct {
        logic d;
        logic first;
        logic last;
    } sbit_t;

    typedef struct {
        logic [N-1:0] word;
        int           stall_at;
        int           stall_len;
        logic [N-1:0] exp_bits;
        logic         exp_par;
    } vec_t;

    logic clk = 1'b0;
    logic clear_n = 1'b0;

    logic [N-1:0] in_data = '0;
    logic in_valid = 1'b0, abort = 1'b0, ser_ready = 1'b1;
    logic in_ready, shld, ser_out, ser_valid, ser_first, ser_last, busy;
    logic [7:0] frame_cnt;

    logic [N-1:0] b_in_data = '0;
    logic b_in_valid = 1'b0, b_abort = 1'b0, b_ser_ready = 1'b1;
    logic b_in_ready, b_shld, b_ser_out, b_ser_valid, b_ser_first, b_ser_last, b_busy;
    logic [7:0] b_frame_cnt;

    sbit_t sb_a[$];
    sbit_t sb_b[$];
    sbit_t ea, eb;
    int checks = 0;
    int errors = 0;
    logic [7:0] frames = 8'd0;
    vec_t vecs[6];

    piso_frame_ctrl #(.N(N), .GAP(1), .CW(8)) dut (
        .clk(clk), .clear_n(clear_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .abort(abort), .shld(shld), .ser_out(ser_out),
        .ser_valid(ser_valid), .ser_ready(ser_ready), .ser_first(ser_first),
        .ser_last(ser_last), .busy(busy), .frame_cnt(frame_cnt)
    );

    piso_frame_ctrl #(.N(N), .GAP(0), .CW(8)) dut_b2b (
        .clk(clk), .clear_n(clear_n), .in_data(b_in_data), .in_valid(b_in_valid),
        .in_ready(b_in_ready), .abort(b_abort), .shld(b_shld), .ser_out(b_ser_out),
        .ser_valid(b_ser_valid), .ser_ready(b_ser_ready), .ser_first(b_ser_first),
        .ser_last(b_ser_last), .busy(b_busy), .frame_cnt(b_frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input bit to_b, input logic [N-1:0] bits, input logic par);
        sbit_t e;
        for (int i = N - 1; i >= 0; i--) begin
            e.d = bits[i];
            e.first = (i == N - 1);
            e.last = (i == 0) && (PAR == 0);
            if (to_b) sb_b.push_back(e); else sb_a.push_back(e);
        end
        if (PAR != 0) begin
            e.d = par; e.first = 1'b0; e.last = 1'b1;
            if (to_b) sb_b.push_back(e); else sb_a.push_back(e);
        end
    endtask

    // Returns at the start of the first-bit cycle (edge k + 1ns).
    task automatic send_a(input logic [N-1:0] w, input logic [N-1:0] bits, input logic par);
        bit got;
        got = 1'b0;
        tick();
        in_data = w;
        in_valid = 1'b1;
        for (int t = 0; t < 40 && !got; t++) begin
            @(negedge clk);
            if (in_ready) got = 1'b1;
            else tick();
        end
        if (got) push_frame(1'b0, bits, par);
        else chk("a_accept_timeout", 32'(got), 32'(1));
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_idle_a();
        bit done;
        done = 1'b0;
        for (int t = 0; t < 60 && !done; t++) begin
            @(negedge clk);
            if (!busy) done = 1'b1;
        end
        if (!done) chk("a_idle_timeout", 32'(done), 32'(1));
    endtask

    // Scoreboard for the GAP=1 instance; abort discards the rest of the frame.
    always @(negedge clk) begin
        if (clear_n) begin
            if (ser_valid && abort) begin
                while (sb_a.size() > 0) begin
                    ea = sb_a.pop_front();
                    if (ea.last) break;
                end
            end else if (ser_valid && ser_ready) begin
                if (sb_a.size() == 0) begin
                    chk("a_unexpected_bit", 32'(sb_a.size()), 32'(1));
                end else begin
                    ea = sb_a.pop_front();
                    chk("a_bit", 32'({ser_out, ser_first, ser_last}), 32'({ea.d, ea.first, ea.last}));
                end
            end
        end
    end

    always @(negedge clk) begin
        if (clear_n && b_ser_valid && b_ser_ready) begin
            if (sb_b.size() == 0) begin
                chk("b_unexpected_bit", 32'(sb_b.size()), 32'(1));
            end else begin
                eb = sb_b.pop_front();
                chk("b_bit", 32'({b_ser_out, b_ser_first, b_ser_last}), 32'({eb.d, eb.first, eb.last}));
            end
        end
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        vecs[0] = '{4'b1011, -1, 0, 4'b1011, 1'b1};
        vecs[1] = '{4'b1011,  1, 3, 4'b1011, 1'b1};
        vecs[2] = '{4'b0000, -1, 0, 4'b0000, 1'b0};
        vecs[3] = '{4'b1111,  2, 1, 4'b1111, 1'b0};
        vecs[4] = '{4'b0110, -1, 0, 4'b0110, 1'b0};
        vecs[5] = '{4'b0001,  0, 2, 4'b0001, 1'b1};

        // Reset state
        #12;
        chk("reset_outs", 32'({in_ready, shld, ser_out, ser_valid, ser_first, ser_last, busy}), 32'(0));
        chk("reset_cnt", 32'(frame_cnt), 32'(0));
        chk("reset_b_ready", 32'(b_in_ready), 32'(0));
        tick();
        clear_n = 1'b1;
        @(negedge clk);
        chk("post_reset_ready", 32'(in_ready), 32'(1));

        // Latency / framing of 4'b1011
        send_a(4'b1011, 4'b1011, 1'b1);
        @(negedge clk);
        chk("lat_first", 32'({ser_valid, ser_first, shld}), 32'(3'b111));
        for (int c = 2; c <= FL; c++) begin
            @(negedge clk);
            if (c == FL) chk("lat_last", 32'({ser_valid, ser_last}), 32'(2'b11));
        end
        @(negedge clk);
        chk("gap_cycle", 32'({in_ready, ser_valid, busy, shld}), 32'(4'b0011));
        @(negedge clk);
        chk("after_gap", 32'({in_ready, busy, shld}), 32'(3'b100));
        frames = frames + 8'd1;
        chk("frame_cnt_1", 32'(frame_cnt), 32'(frames));

        // Table-driven frames with optional stalls
        for (int v = 0; v < 6; v++) begin
            send_a(vecs[v].word, vecs[v].exp_bits, vecs[v].exp_par);
            if (vecs[v].stall_at >= 0) begin
                repeat (vecs[v].stall_at) tick();
                ser_ready = 1'b0;
                for (int j = 0; j < vecs[v].stall_len; j++) begin
                    @(negedge clk);
                    chk("stall_hold", 32'({ser_valid, ser_out}),
                        32'({1'b1, vecs[v].exp_bits[N - 1 - vecs[v].stall_at]}));
                    tick();
                end
                ser_ready = 1'b1;
            end
            wait_idle_a();
            frames = frames + 8'd1;
            chk("vec_frame_cnt", 32'(frame_cnt), 32'(frames));
        end

        // Abort during the 2nd bit
        send_a(4'b1100, 4'b1100, 1'b0);
        tick();
        abort = 1'b1;
        @(negedge clk);
        chk("abort_cycle_valid", 32'(ser_valid), 32'(1));
        tick();
        abort = 1'b0;
        @(negedge clk);
        chk("abort_after", 32'({ser_valid, in_ready, busy}), 32'(3'b010));
        chk("abort_frame_cnt", 32'(frame_cnt), 32'(frames));
        chk("abort_sb_flushed", 32'(sb_a.size()), 32'(0));

        // Abort in IDLE blocks acceptance
        tick();
        in_data = 4'hF;
        in_valid = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        chk("idle_abort_ready", 32'(in_ready), 32'(0));
        repeat (3) tick();
        @(negedge clk);
        chk("idle_abort_busy", 32'(busy), 32'(0));
        tick();
        in_valid = 1'b0;
        abort = 1'b0;

        // Asynchronous reset mid-frame
        send_a(4'b1001, 4'b1001, 1'b0);
        tick();
        #2;
        clear_n = 1'b0;
        #1;
        chk("async_reset_outs", 32'({in_ready, shld, ser_out, ser_valid, ser_first, ser_last, busy}), 32'(0));
        chk("async_reset_cnt", 32'(frame_cnt), 32'(0));
        sb_a.delete();
        frames = 8'd0;
        tick();
        clear_n = 1'b1;
        @(negedge clk);
        chk("release_ready", 32'(in_ready), 32'(1));
        send_a(4'b0110, 4'b0110, 1'b0);
        wait_idle_a();
        frames = frames + 8'd1;
        chk("post_reset_frame", 32'(frame_cnt), 32'(frames));

        // Back-to-back on the GAP=0 instance: 4'hA then 4'h5
        tick();
        b_in_data = 4'hA;
        b_in_valid = 1'b1;
        @(negedge clk);
        chk("b_idle_ready", 32'(b_in_ready), 32'(1));
        push_frame(1'b1, 4'hA, 1'b0);
        tick();
        b_in_data = 4'h5;
        for (int c = 1; c <= 2 * FL; c++) begin
            @(negedge clk);
            chk("b_contiguous", 32'(b_ser_valid), 32'(1));
            if (c == FL) begin
                chk("b_b2b_accept", 32'({b_in_valid, b_in_ready, b_ser_last}), 32'(3'b111));
                push_frame(1'b1, 4'h5, 1'b0);
            end
            tick();
            if (c == FL) b_in_valid = 1'b0;
        end
        @(negedge clk);
        chk("b_done", 32'({b_ser_valid, b_busy}), 32'(0));
        chk("b_frame_cnt", 32'(b_frame_cnt), 32'(2));

        // Frame counter wrap
        while (frames != 8'd255) begin
            send_a(frames[3:0], frames[3:0], ^frames[3:0]);
            wait_idle_a();
            frames = frames + 8'd1;
        end
        chk("cnt_255", 32'(frame_cnt), 32'(255));
        send_a(4'b0011, 4'b0011, 1'b0);
        wait_idle_a();
        chk("cnt_wrap", 32'(frame_cnt), 32'(0));

        chk("sb_a_empty", 32'(sb_a.size()), 32'(0));
        chk("sb_b_empty", 32'(sb_b.size()), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
